// File: rtl/ysyx_22040127_lsu.sv
// Load/store unit: one memory transaction per load/store, passthrough for other ops,
// result handed to writeback over a valid/ready handshake.
module ysyx_22040127_lsu #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic            in_memread,
    input  logic            in_memwrite,
    input  logic [XLEN-1:0] in_alu_output,
    input  logic [XLEN-1:0] in_store_data,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_wen,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [7:0]      mem_req_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_misaligned
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } state_e;

    state_e          r_state;
    state_e          w_state_next;

    logic [2:0]      r_funct3;
    logic [2:0]      r_off;
    logic            r_store;
    logic            r_req_wen;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] r_req_wdata;
    logic [7:0]      r_req_wmask;
    logic [XLEN-1:0] r_result;
    logic            r_misaligned;

    logic [2:0]      w_off;
    logic [7:0]      w_size_mask;
    logic            w_misaligned;
    logic            w_is_mem;
    logic            w_is_store;
    logic            w_accept;
    logic            w_go_req;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_load_data;

    assign w_off      = in_alu_output[2:0];
    assign w_is_mem   = in_memread | in_memwrite;
    // A request flagged as both load and store is handled as a load.
    assign w_is_store = in_memwrite & ~in_memread;
    assign w_accept   = in_valid && (r_state == StIdle);
    assign w_go_req   = w_is_mem && !w_misaligned;

    // Decode access size into a lane mask and detect offsets not aligned to the size.
    always_comb begin
        w_size_mask  = 8'h01;
        w_misaligned = 1'b0;
        unique case (in_funct3[1:0])
            2'b00: begin
                w_size_mask  = 8'h01;
                w_misaligned = 1'b0;
            end
            2'b01: begin
                w_size_mask  = 8'h03;
                w_misaligned = w_off[0];
            end
            2'b10: begin
                w_size_mask  = 8'h0F;
                w_misaligned = |w_off[1:0];
            end
            default: begin
                w_size_mask  = 8'hFF;
                w_misaligned = |w_off;
            end
        endcase
    end

    // Align returned data to bit 0 and extend according to the latched funct3.
    always_comb begin
        w_shifted   = mem_resp_rdata >> {r_off, 3'b000};
        w_load_data = w_shifted;
        unique case (r_funct3)
            3'b000:  w_load_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_data = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            3'b110:  w_load_data = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // Next-state logic of the transaction FSM.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = w_go_req ? StReq : StDone;
                end
            end
            StReq: begin
                if (mem_req_ready) begin
                    w_state_next = r_store ? StDone : StWait;
                end
            end
            StWait: begin
                if (mem_resp_valid) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State, latched instruction fields, request fields and result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_funct3     <= '0;
            r_off        <= '0;
            r_store      <= 1'b0;
            r_req_wen    <= 1'b0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_req_wmask  <= '0;
            r_result     <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_funct3     <= in_funct3;
                r_off        <= w_off;
                r_store      <= w_is_store;
                r_result     <= w_is_mem ? '0 : in_alu_output;
                r_misaligned <= w_is_mem && w_misaligned;
                if (w_go_req) begin
                    r_req_wen   <= w_is_store;
                    r_req_addr  <= {in_alu_output[XLEN-1:3], 3'b000};
                    r_req_wdata <= w_is_store ? (in_store_data << {w_off, 3'b000}) : '0;
                    r_req_wmask <= w_is_store ? (w_size_mask << w_off) : 8'h00;
                end
            end
            if ((r_state == StWait) && mem_resp_valid) begin
                r_result <= w_load_data;
            end
        end
    end

    assign in_ready       = (r_state == StIdle);
    assign mem_req_valid  = (r_state == StReq);
    assign mem_req_wen    = r_req_wen;
    assign mem_req_addr   = r_req_addr;
    assign mem_req_wdata  = r_req_wdata;
    assign mem_req_wmask  = r_req_wmask;
    assign out_valid      = (r_state == StDone);
    assign out_result     = r_result;
    assign out_misaligned = r_misaligned;

endmodule

// File: tb/tb_ysyx_22040127_lsu.sv
// Randomized bench for the LSU against a transaction-level reference model.
module tb_ysyx_22040127_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_memread;
    logic        in_memwrite;
    logic [63:0] in_alu_output;
    logic [63:0] in_store_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_22040127_lsu #(.XLEN(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_funct3      (in_funct3),
        .in_memread     (in_memread),
        .in_memwrite    (in_memwrite),
        .in_alu_output  (in_alu_output),
        .in_store_data  (in_store_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_misaligned (out_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: pick the accessed bytes out of the doubleword and extend them.
    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] off,
                                             input logic [63:0] rd);
        int unsigned nbytes;
        logic [63:0] v;
        logic [63:0] mask;
        nbytes = 1 << f3[1:0];
        v      = rd >> (8 * off);
        mask   = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
        v      = v & mask;
        if (!f3[2] && nbytes < 8 && v[8*nbytes-1]) v = v | ~mask;
        return v;
    endfunction

    // One full instruction: accept, optional memory traffic, writeback handshake.
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] sd,
                           input logic [63:0] rdat, input int req_wait,
                           input int resp_wait, input int out_wait);
        int unsigned nbytes;
        logic [2:0]  off;
        logic        is_mem;
        logic        is_load;
        logic        mis;
        logic [63:0] exp_res;
        logic [7:0]  exp_mask;
        logic [63:0] exp_wdata;
        int          lat;
        int          exp_lat;

        nbytes    = 1 << f3[1:0];
        off       = addr[2:0];
        is_mem    = rd || wr;
        is_load   = rd;
        mis       = is_mem && ((off % nbytes) != 0);
        exp_mask  = 8'(((1 << nbytes) - 1) << off);
        exp_wdata = sd << (8 * off);
        if (!is_mem) exp_res = addr;
        else if (mis || !is_load) exp_res = 64'd0;
        else exp_res = ref_load(f3, off, rdat);
        if (!is_mem || mis) exp_lat = 1;
        else if (!is_load) exp_lat = 2 + req_wait;
        else exp_lat = 3 + req_wait + resp_wait;

        @(negedge clk);
        check_val("in_ready_idle", in_ready, 1'b1);
        check_val("out_valid_idle", out_valid, 1'b0);
        in_valid      = 1'b1;
        in_memread    = rd;
        in_memwrite   = wr;
        in_funct3     = f3;
        in_alu_output = addr;
        in_store_data = sd;
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;

        if (is_mem && !mis) begin
            for (int i = 0; i <= req_wait; i++) begin
                @(negedge clk);
                check_val("req_valid", mem_req_valid, 1'b1);
                check_val("req_addr", mem_req_addr, {addr[63:3], 3'b000});
                check_val("req_wen", mem_req_wen, !is_load);
                check_val("req_wmask", mem_req_wmask, is_load ? 8'h00 : exp_mask);
                if (!is_load) check_val("req_wdata", mem_req_wdata, exp_wdata);
                check_val("out_valid_req", out_valid, 1'b0);
                mem_req_ready = (i == req_wait);
                @(posedge clk);
                lat++;
                #1;
                mem_req_ready = 1'b0;
            end
            if (is_load) begin
                for (int j = 0; j <= resp_wait; j++) begin
                    @(negedge clk);
                    check_val("req_valid_wait", mem_req_valid, 1'b0);
                    check_val("out_valid_wait", out_valid, 1'b0);
                    mem_resp_valid = (j == resp_wait);
                    mem_resp_rdata = (j == resp_wait) ? rdat : {$urandom, $urandom};
                    @(posedge clk);
                    lat++;
                    #1;
                    mem_resp_valid = 1'b0;
                end
            end
        end

        for (int k = 0; k <= out_wait; k++) begin
            @(negedge clk);
            if (k == 0) check_val("latency", 64'(lat), 64'(exp_lat));
            check_val("out_valid", out_valid, 1'b1);
            check_val("out_result", out_result, exp_res);
            check_val("out_misaligned", out_misaligned, mis);
            check_val("in_ready_done", in_ready, 1'b0);
            check_val("req_valid_done", mem_req_valid, 1'b0);
            // Stray traffic that must not disturb the held result.
            mem_resp_valid = $urandom_range(0, 1);
            mem_resp_rdata = {$urandom, $urandom};
            in_valid       = $urandom_range(0, 1);
            in_memread     = 1'b0;
            in_memwrite    = 1'b0;
            in_alu_output  = {$urandom, $urandom};
            out_ready      = (k == out_wait);
            @(posedge clk);
            #1;
            out_ready      = 1'b0;
            mem_resp_valid = 1'b0;
            in_valid       = 1'b0;
        end
    endtask

    initial begin
        logic [2:0]  f3;
        logic [63:0] addr;
        int          kind;

        rst            = 1'b0;
        in_valid       = 1'b0;
        in_funct3      = 3'd0;
        in_memread     = 1'b0;
        in_memwrite    = 1'b0;
        in_alu_output  = 64'd0;
        in_store_data  = 64'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 64'd0;
        out_ready      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_req_valid", mem_req_valid, 1'b0);
        check_val("rst_out_result", out_result, 64'd0);
        check_val("rst_misaligned", out_misaligned, 1'b0);
        check_val("rst_req_addr", mem_req_addr, 64'd0);
        check_val("rst_req_wmask", {56'd0, mem_req_wmask}, 64'd0);
        check_val("rst_req_wen", mem_req_wen, 1'b0);

        // Directed cases.
        run_txn(1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 64'd0, 0, 0, 0);
        run_txn(1'b1, 1'b0, 3'b000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 0);
        run_txn(1'b1, 1'b0, 3'b100, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 0);
        run_txn(1'b0, 1'b1, 3'b001, 64'h8000_0006, 64'hABCD_1234, 64'd0, 3, 0, 0);
        run_txn(1'b0, 1'b1, 3'b010, 64'h8000_0002, 64'h55, 64'd0, 0, 0, 0);
        run_txn(1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 0, 0, 0);
        run_txn(1'b1, 1'b0, 3'b110, 64'h8000_0004, 64'd0, 64'hF000_0000_0000_0000, 0, 0, 5);
        run_txn(1'b1, 1'b1, 3'b111, 64'h8000_0008, 64'h77, 64'h8123_4567_89AB_CDEF, 1, 2, 1);

        // Reset while waiting for a read response; the late response must be dropped.
        @(negedge clk);
        in_valid      = 1'b1;
        in_memread    = 1'b1;
        in_memwrite   = 1'b0;
        in_funct3     = 3'b011;
        in_alu_output = 64'h8000_0010;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("rstwait_req_valid", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check_val("rstwait_out_valid", out_valid, 1'b0);
        check_val("rstwait_in_ready", in_ready, 1'b1);
        check_val("rstwait_req_valid2", mem_req_valid, 1'b0);
        check_val("rstwait_out_result", out_result, 64'd0);
        check_val("rstwait_req_addr", mem_req_addr, 64'd0);
        run_txn(1'b1, 1'b0, 3'b011, 64'h8000_0018, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 0, 0);

        // Randomized mix of passthrough, loads and stores with random stalls.
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 3);
            f3   = 3'($urandom_range(0, 7));
            addr = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFF8)} | 64'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
            if (kind == 0) addr = {$urandom, $urandom};
            run_txn(kind == 1 || kind == 3, kind == 2 || kind == 3, f3, addr,
                    {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22040127_lsu.md
Name: ysyx_22040127_lsu

Overview:
- Memory-access stage directly downstream of the execute stage. It takes the ALU result (effective address or plain result), the store data and the load/store control for one instruction.
- For loads and stores it runs one transaction on a simple valid/ready data-memory port: 64-bit aligned address, byte-lane mask, data shifted onto the correct lanes.
- For loads it extracts and sign- or zero-extends the returned data.
- It hands one result per instruction to writeback over a valid/ready handshake.

Parameters:
- XLEN, 64, datapath and address width. Only 64 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low: state resets on a rising clk edge while rst==0.
- in_valid  input  1  execute presents an instruction.
- in_ready  output  1  stage can accept an instruction.
- in_funct3  input  3  instruction[14:12]: access size and signedness.
- in_memread  input  1  instruction is a load.
- in_memwrite  input  1  instruction is a store.
- in_alu_output  input  64  effective address (load/store), otherwise the final result.
- in_store_data  input  64  rs2 value for stores.
- mem_req_valid  output  1  memory request valid.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_wen  output  1  1 = write, 0 = read.
- mem_req_addr  output  64  {in_alu_output[63:3], 3'b000}.
- mem_req_wdata  output  64  store data shifted onto byte lanes.
- mem_req_wmask  output  8  byte-lane enables; 0 for reads.
- mem_resp_valid  input  1  read data valid; exactly one pulse per accepted read.
- mem_resp_rdata  input  64  aligned 64-bit read data.
- out_valid  output  1  result available for writeback.
- out_ready  input  1  writeback accepts the result.
- out_result  output  64  loaded value or passthrough ALU result; 0 for stores.
- out_misaligned  output  1  access was misaligned; no memory traffic issued.

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- Reset values: mem_req_valid=0, out_valid=0, out_result=0, out_misaligned=0, mem_req_wen=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wmask=0. in_ready=1 (combinational, equals state==IDLE).
- Accept: in_valid && in_ready at edge T latches all in_* fields.
- Non-memory op (memread=memwrite=0): go to DONE. out_result=alu_output and out_valid=1 from T+1.
- memread and memwrite both set: treat as load.
- Size from funct3[1:0]: 00 byte, 01 half, 10 word, 11 double.
- Misaligned when the address offset addr[2:0] is not a multiple of the size. In that case go straight to DONE with out_misaligned=1, out_result=0, and never assert mem_req_valid.
- Aligned load/store: go to REQ. mem_req_valid=1 from T+1 and held, with all request fields stable, until the handshake (mem_req_valid && mem_req_ready).
  - wmask = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
  - wdata = store_data << (8*addr[2:0]).
- Store: the request handshake completes it. Go to DONE with out_result=0.
- Load: the handshake moves to WAIT. On mem_resp_valid in WAIT, shift rdata right by 8*addr[2:0] and extend to 64 bits:
  - signed when funct3[2]=0;
  - zero-extended when funct3[2]=1 (LBU/LHU/LWU);
  - funct3=111 is treated as LD.
  - Then go to DONE.
- mem_resp_valid outside WAIT is ignored.
- DONE: out_valid held with out_result/out_misaligned stable until out_ready. On the handshake go to IDLE.
  - No accept in the same cycle as the handshake: in_ready=0 in DONE, so sustained throughput is at most one instruction per 2 cycles.
- Minimum latency, accept to out_valid:
  - non-memory: 1 cycle;
  - store: 2 cycles with mem_req_ready=1;
  - load: 3 cycles with the response on the cycle after the request handshake.
- Reset mid-operation: return to IDLE and clear all outputs to reset values. A read response arriving after reset is dropped.

Test Plan:
- ADD passthrough: alu_output=0x1234, out_ready=1 -> out_valid at T+1, out_result=0x1234, no mem_req_valid.
- LB at 0x8000_0003, rdata=0x0000_0000_8000_0000 -> mem_req_addr=0x8000_0000, wmask=0, out_result=0xFFFF_FFFF_FFFF_FF80. The same access as LBU -> 0x80.
- SH at 0x8000_0006, store_data=0xABCD_1234, mem_req_ready low 3 cycles -> request held stable 4 cycles, wmask=0xC0, wdata=0x1234_0000_0000_0000, then out_valid with out_result=0.
- LW at 0x8000_0002 -> out_misaligned=1 and out_result=0 at T+1, mem_req_valid never asserted.
- LWU at 0x8000_0004, rdata=0xF000_0000_0000_0000, out_ready low 5 cycles -> out_result=0x0000_0000_F000_0000 held 6 cycles, in_ready=0 throughout.
- rst=0 while in WAIT, then a late mem_resp_valid -> IDLE, out_valid stays 0, in_ready=1, next LD completes normally.
